// File: rtl/uart_fifo.sv
// UART with TX/RX FIFOs and a small register file: 8N1-style framing with optional
// parity, runtime baud divisor, sticky error flags and a level interrupt.

module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

module uart_fifo #(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PARITY     = 0,
    parameter logic [15:0] DIV_RESET  = 16'h007F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  reg_num,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);
    localparam int DW = DATA_BITS;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [15:0] div;
    logic [1:0]  ctrl;
    logic        ovr, ferr, perr, irq_q;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [DW-1:0] tx_head;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic [DW-1:0] rx_head;

    logic wr_tx, wr_st, wr_div, wr_ctrl;
    assign wr_tx   = we && (reg_num == 3'd0);
    assign wr_st   = we && (reg_num == 3'd2);
    assign wr_div  = we && (reg_num == 3'd3);
    assign wr_ctrl = we && (reg_num == 3'd4);

    logic unused_wd;
    assign unused_wd = &{1'b0, wd[31:16]};

    // ---------------- TX path ----------------
    state_t        tx_state, tx_state_n;
    logic [15:0]   tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [3:0]    tx_bit, tx_bit_n;
    logic [DW-1:0] tx_shift, tx_shift_n;
    logic          tx_par, tx_par_n, tx_line, tx_line_n, tx_load;

    assign tx_push = wr_tx && (!tx_full || tx_pop);

    uart_fifo_buf #(.W(DW), .DEPTH(FIFO_DEPTH)) u_txf (
        .clk(clk), .rst(rst), .push(tx_push), .din(wd[DW-1:0]), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE:  tx_load = !tx_empty;
            S_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = tx_div;
                    tx_bit_n   = '0;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            S_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n   = tx_div;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == 4'(DW-1)) tx_state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    else tx_bit_n = tx_bit + 4'd1;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            S_PAR: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = S_STOP;
                    tx_cnt_n   = tx_div;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            S_STOP: begin
                if (tx_cnt == 16'd0) begin
                    if (!tx_empty) tx_load = 1'b1;
                    else tx_state_n = S_IDLE;
                end else tx_cnt_n = tx_cnt - 16'd1;
            end
            default: tx_state_n = S_IDLE;
        endcase
        // Divisor is captured per frame so a DIV write never stretches a bit mid-frame.
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_n = S_START;
            tx_shift_n = tx_head;
            tx_div_n   = div;
            tx_cnt_n   = div;
            tx_par_n   = (PARITY == 2) ? ~(^tx_head) : ^tx_head;
        end
        // The line is registered from the current state, so it lags the FSM by one cycle.
        case (tx_state)
            S_START: tx_line_n = 1'b0;
            S_DATA:  tx_line_n = tx_shift[0];
            S_PAR:   tx_line_n = tx_par;
            default: tx_line_n = 1'b1;
        endcase
    end

    assign tx = tx_line;

    // ---------------- RX path ----------------
    state_t        rx_state, rx_state_n;
    logic [15:0]   rx_cnt, rx_cnt_n, rx_div, rx_div_n, half, half_cnt;
    logic [16:0]   div_inc;
    logic [3:0]    rx_bit, rx_bit_n;
    logic [DW-1:0] rx_shift, rx_shift_n;
    logic          rx_perr, rx_perr_n, rx_done;
    logic          rx_meta, rx_sync, rx_prev;

    assign div_inc  = {1'b0, div} + 17'd1;
    assign half     = div_inc[16:1];
    assign half_cnt = (half == 16'd0) ? 16'd0 : half - 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_perr  <= rx_perr_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_perr_n  = rx_perr;
        rx_done    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = S_START;
                    rx_div_n   = div;
                    rx_cnt_n   = half_cnt;
                end
            end
            S_START: begin
                // Mid-bit re-check of the start bit rejects short glitches.
                if (rx_cnt == 16'd0) begin
                    if (rx_sync) rx_state_n = S_IDLE;
                    else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = rx_div;
                        rx_bit_n   = '0;
                        rx_perr_n  = 1'b0;
                    end
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            S_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_cnt_n   = rx_div;
                    rx_shift_n = {rx_sync, rx_shift[DW-1:1]};
                    if (rx_bit == 4'(DW-1)) rx_state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    else rx_bit_n = rx_bit + 4'd1;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            S_PAR: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_n = S_STOP;
                    rx_cnt_n   = rx_div;
                    rx_perr_n  = rx_sync != ((PARITY == 2) ? ~(^rx_shift) : ^rx_shift);
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            S_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_done    = 1'b1;
                    rx_state_n = S_IDLE;
                end else rx_cnt_n = rx_cnt - 16'd1;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    assign rx_pop  = re && (reg_num == 3'd1) && !rx_empty;
    assign rx_push = rx_done && (!rx_full || rx_pop);

    uart_fifo_buf #(.W(DW), .DEPTH(FIFO_DEPTH)) u_rxf (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_shift), .pop(rx_pop),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // ---------------- registers ----------------
    logic [2:0] clr;
    assign clr = wr_st ? wd[7:5] : 3'b000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= DIV_RESET;
            ctrl  <= '0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_div)  div  <= wd[15:0];
            if (wr_ctrl) ctrl <= wd[1:0];
            ovr   <= (ovr  & ~clr[0]) | (rx_done & rx_full & !rx_pop);
            ferr  <= (ferr & ~clr[1]) | (rx_done & !rx_sync);
            perr  <= (perr & ~clr[2]) | (rx_done & rx_perr);
            irq_q <= (ctrl[1] & !rx_empty) | (ctrl[0] & tx_empty);
        end
    end

    assign irq = irq_q;

    always_comb begin
        rd = '0;
        case (reg_num)
            3'd1:    rd = rx_empty ? 32'd0 : 32'(rx_head);
            3'd2:    rd = {24'd0, perr, ferr, ovr, (tx_state != S_IDLE),
                           rx_full, rx_empty, tx_empty, tx_full};
            3'd3:    rd = {16'd0, div};
            3'd4:    rd = {30'd0, ctrl};
            default: rd = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: register table, TX waveform, loopback scoreboard,
// parity/framing errors, glitch rejection and mid-frame reset.

module tb_uart_fifo;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0;
    logic [2:0]  reg_num = 3'd0;
    logic [31:0] wd = 32'd0;
    logic        rx_drv = 1'b1, loop = 1'b0;
    logic [31:0] rd0, rd1;
    logic        tx0, tx1, irq0, irq1, rx0;

    assign rx0 = loop ? tx0 : 1'b1;

    always #5 clk = ~clk;

    uart_fifo dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .reg_num(reg_num), .wd(wd),
        .rd(rd0), .rx(rx0), .tx(tx0), .irq(irq0)
    );

    uart_fifo #(.PARITY(1)) dut_p (
        .clk(clk), .rst(rst), .we(we), .re(re), .reg_num(reg_num), .wd(wd),
        .rd(rd1), .rx(rx_drv), .tx(tx1), .irq(irq1)
    );

    int checks = 0, errors = 0;
    logic [7:0] sb0[$], sb1[$];

    typedef struct {
        logic        wr_en;
        logic [2:0]  r;
        logic [31:0] d;
        logic [31:0] exp;
        logic        exp_irq;
        string       name;
    } vec_t;
    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        @(posedge clk); #1;
        we = 1'b1; reg_num = r; wd = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rdreg(input int which, input logic [2:0] r, output logic [31:0] d);
        @(posedge clk); #1;
        reg_num = r;
        @(negedge clk);
        d = (which != 0) ? rd1 : rd0;
    endtask

    task automatic pop(input int which, output logic [31:0] d);
        @(posedge clk); #1;
        reg_num = 3'd1; re = 1'b1;
        @(negedge clk);
        d = (which != 0) ? rd1 : rd0;
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        rx_drv = b;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        @(posedge clk); #1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(par);
        send_bit(stop);
        rx_drv = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_tx_low(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!tx0) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got, st;
        logic [9:0]  frame;
        logic [7:0]  e;
        int          lat;
        logic        ok;

        vt[0]  = '{1'b0, 3'd2, 32'h0,        32'h06,   1'b0, "rst_status"};
        vt[1]  = '{1'b0, 3'd3, 32'h0,        32'h7F,   1'b0, "rst_div"};
        vt[2]  = '{1'b0, 3'd4, 32'h0,        32'h0,    1'b0, "rst_ctrl"};
        vt[3]  = '{1'b0, 3'd1, 32'h0,        32'h0,    1'b0, "rxdata_empty"};
        vt[4]  = '{1'b0, 3'd7, 32'h0,        32'h0,    1'b0, "reg7_zero"};
        vt[5]  = '{1'b1, 3'd3, 32'h1234,     32'h1234, 1'b0, "div_rw"};
        vt[6]  = '{1'b1, 3'd3, 32'hABCD5678, 32'h5678, 1'b0, "div_mask"};
        vt[7]  = '{1'b1, 3'd4, 32'hFFFFFFFF, 32'h3,    1'b1, "ctrl_mask"};
        vt[8]  = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0,    1'b1, "reg5_ignored"};
        vt[9]  = '{1'b1, 3'd4, 32'h2,        32'h2,    1'b0, "ctrl_rxie"};
        vt[10] = '{1'b1, 3'd4, 32'h0,        32'h0,    1'b0, "ctrl_clear"};
        vt[11] = '{1'b1, 3'd3, 32'h3,        32'h3,    1'b0, "div_set3"};
        vt[12] = '{1'b1, 3'd2, 32'hFF,       32'h06,   1'b0, "status_w1c_noset"};

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_irq", {31'd0, irq0}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            if (vt[i].wr_en) wr(vt[i].r, vt[i].d);
            rdreg(0, vt[i].r, got);
            check(vt[i].name, got, vt[i].exp);
            check({vt[i].name, "_irq"}, {31'd0, irq0}, {31'd0, vt[i].exp_irq});
        end

        // Single frame, DIV=3: 4 cycles per bit
        wr(3'd0, 32'h55);
        wait_tx_low(lat);
        check("tx_start_latency", lat, 3);
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("tx_wave_%0d", k), {31'd0, tx0}, {31'd0, frame[k/4]});
        end
        repeat (3) @(negedge clk);
        rdreg(0, 3'd2, st);
        check("tx_done_status", st & 32'h1F, 32'h06);

        // Loopback: 8 frames fill RX, the ninth overruns
        loop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr(3'd0, 32'(i));
            sb0.push_back(8'(i));
        end
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            rdreg(0, 3'd2, st);
            if (st[3]) ok = 1'b1;
        end
        check("rx_full_reached", {31'd0, ok}, 32'd1);
        check("rx_full_no_ovr", st & 32'h28, 32'h08);
        wr(3'd0, 32'h08);
        repeat (100) @(posedge clk);
        rdreg(0, 3'd2, st);
        check("ovr_set", st & 32'h28, 32'h28);
        for (int i = 0; i < 8; i++) begin
            pop(0, got);
            e = sb0.pop_front();
            check($sformatf("loop_pop_%0d", i), got, 32'(e));
        end
        rdreg(0, 3'd2, st);
        check("rx_empty_after_pops", st & 32'h0C, 32'h04);
        wr(3'd2, 32'h20);
        rdreg(0, 3'd2, st);
        check("ovr_cleared", st & 32'h20, 32'h0);
        loop = 1'b0;

        // Even-parity receiver: parity error, framing error, clean frame
        sb1.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b1);
        rdreg(1, 3'd2, st);
        check("perr_set", st & 32'hE4, 32'h80);
        pop(1, got);
        check("perr_data", got, 32'(sb1.pop_front()));
        wr(3'd2, 32'h80);
        rdreg(1, 3'd2, st);
        check("perr_cleared", st & 32'h80, 32'h0);

        sb1.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0);
        rdreg(1, 3'd2, st);
        check("ferr_set", st & 32'hE4, 32'h40);
        pop(1, got);
        check("ferr_data", got, 32'(sb1.pop_front()));
        wr(3'd2, 32'h40);
        rdreg(1, 3'd2, st);
        check("ferr_cleared", st & 32'h40, 32'h0);

        sb1.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        rdreg(1, 3'd2, st);
        check("par_ok_status", st & 32'hE4, 32'h00);
        pop(1, got);
        check("par_ok_data", got, 32'(sb1.pop_front()));

        // One-cycle glitch must not start a frame
        @(posedge clk); #1;
        rx_drv = 1'b0;
        @(posedge clk); #1;
        rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        rdreg(1, 3'd2, st);
        check("glitch_no_push", st & 32'hE4, 32'h04);
        sb1.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1);
        pop(1, got);
        check("after_glitch_data", got, 32'(sb1.pop_front()));

        // Reset in the middle of a frame
        wr(3'd4, 32'h1);
        wr(3'd0, 32'h00);
        wait_tx_low(lat);
        check("rst_test_tx_started", {31'd0, (lat != 0)}, 32'd1);
        repeat (10) @(negedge clk);
        check("mid_frame_tx_low", {31'd0, tx0}, 32'd0);
        check("mid_frame_irq", {31'd0, irq0}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_tx", {31'd0, tx0}, 32'd1);
        check("async_rst_irq", {31'd0, irq0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdreg(0, 3'd2, st);
        check("post_rst_status", st, 32'h06);
        rdreg(0, 3'd3, got);
        check("post_rst_div", got, 32'h7F);
        rdreg(0, 3'd4, got);
        check("post_rst_ctrl", got, 32'h0);
        repeat (12) @(negedge clk);
        check("post_rst_tx_idle", {31'd0, tx0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
